// File: rtl/fsm_timer_control.sv
// -----------------------------------------------------------------------------
// fsm_timer_control
//   Timing helper for a main exposure FSM. It has three jobs:
//     * It holds a programmable exposure length (o_Exp_time). The length is
//       adjusted by +/-1 per cycle while the main FSM is idle, and it
//       saturates at P_EXP_MIN and P_EXP_MAX.
//     * It runs an exposure countdown (o_count_time). The countdown reloads
//       while idle, counts down to 0 during exposure, and holds during readout.
//     * It sequences the readout (o_RD_FSM):
//       INIT -> NRE_1 -> ADC_1 -> NOTHING -> NRE_2 -> ADC_2 -> END.
//
// Ports
//   i_Clock         rising-edge clock
//   i_Reset         synchronous, active-high reset
//   i_Main_FSM[1:0] main state: 00 idle, 01 exposure, 10 readout, 11 = idle
//   i_Exp_increase  level request: exposure length +1
//   i_Exp_decrease  level request: exposure length -1
//   o_count_time    exposure countdown
//   o_RD_FSM        readout state code
//   o_Exp_time      programmed exposure length
// -----------------------------------------------------------------------------
module fsm_timer_control #(
    parameter logic [4:0] P_EXP_DEFAULT = 5'd5,
    parameter logic [4:0] P_EXP_MIN     = 5'd2,
    parameter logic [4:0] P_EXP_MAX     = 5'd30,
    parameter int         P_NRE_LEN     = 2,
    parameter int         P_ADC_LEN     = 2,
    parameter int         P_GAP_LEN     = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic [1:0] i_Main_FSM,
    input  logic       i_Exp_increase,
    input  logic       i_Exp_decrease,
    output logic [4:0] o_count_time,
    output logic [2:0] o_RD_FSM,
    output logic [4:0] o_Exp_time
);

    typedef enum logic [2:0] {
        s_init    = 3'b000,
        s_nre_1   = 3'b001,
        s_adc_1   = 3'b010,
        s_nothing = 3'b011,
        s_nre_2   = 3'b100,
        s_adc_2   = 3'b101,
        s_end     = 3'b110
    } rd_state_e;

    // The phase counter only has to reach (longest timed state - 1).
    localparam int MAX_LEN_A = (P_NRE_LEN > P_ADC_LEN) ? P_NRE_LEN : P_ADC_LEN;
    localparam int MAX_LEN   = (MAX_LEN_A > P_GAP_LEN) ? MAX_LEN_A : P_GAP_LEN;
    localparam int PH_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [PH_W-1:0] NRE_LAST = PH_W'(P_NRE_LEN - 1);
    localparam logic [PH_W-1:0] ADC_LAST = PH_W'(P_ADC_LEN - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(P_GAP_LEN - 1);

    rd_state_e       state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [4:0]      exp_q, exp_d;
    logic [4:0]      count_q, count_d;

    logic            is_expo, is_ro, is_idle;
    logic            timed;
    logic [PH_W-1:0] last;
    rd_state_e       nxt;

    always_comb begin
        is_expo = (i_Main_FSM == 2'b01);
        is_ro   = (i_Main_FSM == 2'b10);
        // Code 11 is treated as idle.
        is_idle = !is_expo && !is_ro;
    end

    // Exposure length and countdown
    always_comb begin
        exp_d   = exp_q;
        count_d = count_q;
        if (is_idle) begin
            // The countdown takes the current length. Any adjustment made on
            // this edge shows up in the countdown one cycle later.
            count_d = exp_q;
            if (i_Exp_increase && !i_Exp_decrease && (exp_q < P_EXP_MAX))
                exp_d = exp_q + 5'd1;
            else if (i_Exp_decrease && !i_Exp_increase && (exp_q > P_EXP_MIN))
                exp_d = exp_q - 5'd1;
        end else if (is_expo) begin
            if (count_q != 5'd0)
                count_d = count_q - 5'd1;
        end
    end

    // Readout sequencer. Each timed state is described by its last phase value
    // and its successor, so a single advance rule below covers all of them.
    always_comb begin
        timed = 1'b0;
        last  = '0;
        nxt   = state_q;
        case (state_q)
            s_nre_1:   begin timed = 1'b1; last = NRE_LAST; nxt = s_adc_1;   end
            s_adc_1:   begin timed = 1'b1; last = ADC_LAST; nxt = s_nothing; end
            s_nothing: begin timed = 1'b1; last = GAP_LAST; nxt = s_nre_2;   end
            s_nre_2:   begin timed = 1'b1; last = NRE_LAST; nxt = s_adc_2;   end
            s_adc_2:   begin timed = 1'b1; last = ADC_LAST; nxt = s_end;     end
            default:   begin timed = 1'b0; last = '0;       nxt = state_q;   end
        endcase
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!is_ro) begin
            // Leaving readout aborts the sequence at any point.
            state_d = s_init;
            phase_d = '0;
        end else if (state_q == s_init) begin
            state_d = s_nre_1;
            phase_d = '0;
        end else if (timed) begin
            if (phase_q == last) begin
                state_d = nxt;
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end else if (state_q != s_end) begin
            // Unused code 111: recover to INIT.
            state_d = s_init;
            phase_d = '0;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= s_init;
            phase_q <= '0;
            exp_q   <= P_EXP_DEFAULT;
            count_q <= P_EXP_DEFAULT;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            exp_q   <= exp_d;
            count_q <= count_d;
        end
    end

    assign o_RD_FSM     = state_q;
    assign o_Exp_time   = exp_q;
    assign o_count_time = count_q;

endmodule

// File: tb/tb_fsm_timer_control.sv
// -----------------------------------------------------------------------------
// tb_fsm_timer_control
//   This bench uses directed scenarios followed by a randomized run. A
//   behavioural model tracks the expected values: the exposure length, the
//   countdown, and the number of consecutive readout edges. The expected
//   readout code is derived from that edge count. A compare process checks
//   the DUT against the model on every falling edge. Literal checks are also
//   placed at key points.
// -----------------------------------------------------------------------------
module tb_fsm_timer_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] main_fsm;
    logic       inc, dec;
    logic [4:0] count_time, exp_time;
    logic [2:0] rd_fsm;

    fsm_timer_control dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Main_FSM     (main_fsm),
        .i_Exp_increase (inc),
        .i_Exp_decrease (dec),
        .o_count_time   (count_time),
        .o_RD_FSM       (rd_fsm),
        .o_Exp_time     (exp_time)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state
    int m_exp = 5;
    int m_cnt = 5;
    int m_n   = 0;   // consecutive edges sampled with main = readout

    // Readout code as a function of how many readout edges have elapsed.
    function automatic int rd_of(int n);
        int dur[5] = '{2, 2, 1, 2, 2};
        int acc = 0;
        if (n == 0) return 0;
        for (int k = 0; k < 5; k++) begin
            acc += dur[k];
            if (n <= acc) return k + 1;
        end
        return 6;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_exp = 5;
            m_cnt = 5;
            m_n   = 0;
        end else begin
            if (main_fsm == 2'b10) m_n = m_n + 1;
            else                   m_n = 0;
            if (main_fsm == 2'b01) begin
                m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
            end else if (main_fsm != 2'b10) begin
                m_cnt = m_exp;
                if (inc && !dec)      m_exp = (m_exp < 30) ? m_exp + 1 : 30;
                else if (dec && !inc) m_exp = (m_exp > 2)  ? m_exp - 1 : 2;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_exp_time",   int'(exp_time),   m_exp);
            chk("model_count_time", int'(count_time), m_cnt);
            chk("model_rd_fsm",     int'(rd_fsm),     rd_of(m_n));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ex[7]  = '{4, 3, 2, 1, 0, 0, 0};
        int ro[12] = '{1, 1, 2, 2, 3, 4, 4, 5, 5, 6, 6, 6};
        rst = 1'b1; main_fsm = 2'b00; inc = 1'b0; dec = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        chk("reset_exp", int'(exp_time), 5);
        chk("reset_cnt", int'(count_time), 5);
        chk("reset_rd",  int'(rd_fsm), 0);
        rst = 1'b0;

        repeat (3) tick();
        chk("idle_exp", int'(exp_time), 5);
        chk("idle_cnt", int'(count_time), 5);
        chk("idle_rd",  int'(rd_fsm), 0);

        inc = 1'b1;
        repeat (30) tick();
        chk("sat_max", int'(exp_time), 30);
        inc = 1'b0;
        tick();
        chk("cnt_follows_max", int'(count_time), 30);

        dec = 1'b1;
        repeat (30) tick();
        chk("sat_min", int'(exp_time), 2);
        inc = 1'b1;
        repeat (3) tick();
        chk("both_hold", int'(exp_time), 2);
        chk("both_cnt", int'(count_time), 2);

        dec = 1'b0;
        repeat (3) tick();
        chk("back_to_5", int'(exp_time), 5);
        inc = 1'b0;
        tick();
        chk("cnt_reload_5", int'(count_time), 5);

        // Exposure countdown; a request during exposure must be ignored.
        main_fsm = 2'b01; inc = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("expo_cnt", int'(count_time), ex[i]);
        end
        chk("expo_ignores_req", int'(exp_time), 5);
        inc = 1'b0;

        main_fsm = 2'b10;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("ro_seq", int'(rd_fsm), ro[i]);
        end
        chk("ro_cnt_hold", int'(count_time), 0);

        main_fsm = 2'b00;
        tick();
        chk("exit_after_end", int'(rd_fsm), 0);

        main_fsm = 2'b10;
        repeat (3) tick();
        chk("in_adc1", int'(rd_fsm), 2);
        main_fsm = 2'b00;
        tick();
        chk("abort_adc1", int'(rd_fsm), 0);

        main_fsm = 2'b10;
        repeat (7) tick();
        chk("in_nre2", int'(rd_fsm), 4);
        rst = 1'b1;
        tick();
        chk("rst_rd", int'(rd_fsm), 0);
        chk("rst_cnt", int'(count_time), 5);
        rst = 1'b0;
        tick();
        chk("restart_nre1", int'(rd_fsm), 1);

        // Randomized run. The main state changes only occasionally, so that
        // long readout runs occur.
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: main_fsm = 2'b00;
                    3:       main_fsm = 2'b11;
                    4, 5:    main_fsm = 2'b01;
                    default: main_fsm = 2'b10;
                endcase
            end
            inc = ($urandom_range(0, 2) == 0);
            dec = ($urandom_range(0, 2) == 0);
            tick();
        end

        rst = 1'b0; main_fsm = 2'b00; inc = 1'b0; dec = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
